dpbram_frame_sched: RTL and testbench

Frame scheduler and arbiter for the Zynq-to-DSP XINTF DPBRAM write port. Each sample tick it writes one coherent frame: current and voltage ADC feedback words, then up to `CFG_PER_FRAME` queued 32-bit configuration writes. It then signals frame completion to the DSP over the `o_w_valid`/`i_w_ready` handshake. It sits between the core register/ADC capture logic and the DPBRAM write port, and is the only master driving that port.

---
 rtl/dpbram_frame_sched.sv | 196 +++++++++++++++++++
 tb/tb_dpbram_frame_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpbram_frame_sched.sv
// Frame scheduler for the XINTF DPBRAM write port: per tick, writes the ADC
// feedback words, then up to CFG_PER_FRAME queued config writes, then handshakes with the DSP.
module dpbram_frame_sched #(
    parameter int ADDR_WIDTH    = 9,
    parameter int FAST_BASE     = 0,
    parameter int CFG_PER_FRAME = 2,
    parameter int WAIT_TIMEOUT  = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tick,
    input  logic [31:0]           i_c_data,
    input  logic [31:0]           i_v_data,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [ADDR_WIDTH-1:0] i_cfg_addr,
    input  logic [31:0]           i_cfg_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_ce,
    output logic                  o_we,
    output logic [15:0]           o_din,
    output logic                  o_w_valid,
    input  logic                  i_w_ready,
    input  logic                  i_clr,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic                  o_timeout,
    output logic [15:0]           o_frame_cnt
);

    localparam int TW = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] FAST_ADDR0 = ADDR_WIDTH'(FAST_BASE);
    localparam logic [ADDR_WIDTH-1:0] FAST_ADDR1 = ADDR_WIDTH'(FAST_BASE + 1);
    localparam logic [ADDR_WIDTH-1:0] FAST_ADDR2 = ADDR_WIDTH'(FAST_BASE + 2);
    localparam logic [ADDR_WIDTH-1:0] FAST_ADDR3 = ADDR_WIDTH'(FAST_BASE + 3);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FAST0,
        S_FAST1,
        S_FAST2,
        S_FAST3,
        S_CFG_ACC,
        S_CFG_LO,
        S_CFG_HI,
        S_SIGNAL
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [31:0]             c_q;
    logic [31:0]             v_q;
    logic [31:0]             cfg_data_q;
    logic [ADDR_WIDTH-1:0]   cfg_addr_q;
    logic [3:0]              credit;
    logic [TW-1:0]           wait_cnt;

    logic                    frame_start;
    logic                    cfg_take;
    logic                    handshake;
    logic                    timeout_hit;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [15:0]             wr_din;

    assign frame_start = (state == S_IDLE) && i_tick;
    assign cfg_take    = (state == S_CFG_ACC) && i_cfg_valid;
    assign handshake   = (state == S_SIGNAL) && i_w_ready;
    assign timeout_hit = (state == S_SIGNAL) && !i_w_ready
                         && (wait_cnt == TW'(WAIT_TIMEOUT - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:    if (i_tick) state_next = S_FAST0;
            S_FAST0:   state_next = S_FAST1;
            S_FAST1:   state_next = S_FAST2;
            S_FAST2:   state_next = S_FAST3;
            S_FAST3:   state_next = S_CFG_ACC;
            S_CFG_ACC: state_next = cfg_take ? S_CFG_LO : S_SIGNAL;
            S_CFG_LO:  state_next = S_CFG_HI;
            S_CFG_HI:  state_next = (credit != 4'd0) ? S_CFG_ACC : S_SIGNAL;
            S_SIGNAL:  if (handshake || timeout_hit) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Write port contents are chosen from the state being entered so the bus is registered.
    // FAST0 and CFG_LO are entered on the same edge that captures their source, so they read the inputs.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_din  = '0;
        case (state_next)
            S_FAST0: begin
                wr_en   = 1'b1;
                wr_addr = FAST_ADDR0;
                wr_din  = i_c_data[15:0];
            end
            S_FAST1: begin
                wr_en   = 1'b1;
                wr_addr = FAST_ADDR1;
                wr_din  = c_q[31:16];
            end
            S_FAST2: begin
                wr_en   = 1'b1;
                wr_addr = FAST_ADDR2;
                wr_din  = v_q[15:0];
            end
            S_FAST3: begin
                wr_en   = 1'b1;
                wr_addr = FAST_ADDR3;
                wr_din  = v_q[31:16];
            end
            S_CFG_LO: begin
                wr_en   = 1'b1;
                wr_addr = i_cfg_addr;
                wr_din  = i_cfg_data[15:0];
            end
            S_CFG_HI: begin
                wr_en   = 1'b1;
                wr_addr = cfg_addr_q + ADDR_WIDTH'(1);
                wr_din  = cfg_data_q[31:16];
            end
            default: begin
                wr_en   = 1'b0;
                wr_addr = '0;
                wr_din  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            c_q         <= '0;
            v_q         <= '0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            credit      <= '0;
            wait_cnt    <= '0;
            o_ce        <= 1'b0;
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_din       <= '0;
            o_cfg_ready <= 1'b0;
            o_w_valid   <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
            o_timeout   <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            state <= state_next;

            if (frame_start) begin
                c_q    <= i_c_data;
                v_q    <= i_v_data;
                credit <= 4'(CFG_PER_FRAME);
            end

            if (cfg_take) begin
                cfg_addr_q <= i_cfg_addr;
                cfg_data_q <= i_cfg_data;
                credit     <= credit - 4'd1;
            end

            if (state == S_SIGNAL) wait_cnt <= wait_cnt + TW'(1);
            else                   wait_cnt <= '0;

            o_ce <= wr_en;
            o_we <= wr_en;
            if (wr_en) begin
                o_addr <= wr_addr;
                o_din  <= wr_din;
            end

            o_cfg_ready <= (state_next == S_CFG_ACC);
            o_w_valid   <= (state_next == S_SIGNAL);
            o_busy      <= (state_next != S_IDLE);

            if (handshake) o_frame_cnt <= o_frame_cnt + 16'd1;

            // Set events take priority over a coincident clear.
            if (i_tick && state != S_IDLE) o_overrun <= 1'b1;
            else if (i_clr)                o_overrun <= 1'b0;

            if (timeout_hit) o_timeout <= 1'b1;
            else if (i_clr)  o_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dpbram_frame_sched.sv
// Scoreboard bench for dpbram_frame_sched: expected DPBRAM writes are queued
// with their cycle when a frame is launched and popped as the write port fires.
module tb_dpbram_frame_sched;

    localparam int AW  = 9;
    localparam int CPF = 2;
    localparam int WT  = 16;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_tick;
    logic [31:0]   i_c_data;
    logic [31:0]   i_v_data;
    logic          i_cfg_valid;
    logic          o_cfg_ready;
    logic [AW-1:0] i_cfg_addr;
    logic [31:0]   i_cfg_data;
    logic [AW-1:0] o_addr;
    logic          o_ce;
    logic          o_we;
    logic [15:0]   o_din;
    logic          o_w_valid;
    logic          i_w_ready;
    logic          i_clr;
    logic          o_busy;
    logic          o_overrun;
    logic          o_timeout;
    logic [15:0]   o_frame_cnt;

    dpbram_frame_sched #(
        .ADDR_WIDTH   (AW),
        .FAST_BASE    (0),
        .CFG_PER_FRAME(CPF),
        .WAIT_TIMEOUT (WT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_tick     (i_tick),
        .i_c_data   (i_c_data),
        .i_v_data   (i_v_data),
        .i_cfg_valid(i_cfg_valid),
        .o_cfg_ready(o_cfg_ready),
        .i_cfg_addr (i_cfg_addr),
        .i_cfg_data (i_cfg_data),
        .o_addr     (o_addr),
        .o_ce       (o_ce),
        .o_we       (o_we),
        .o_din      (o_din),
        .o_w_valid  (o_w_valid),
        .i_w_ready  (i_w_ready),
        .i_clr      (i_clr),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun),
        .o_timeout  (o_timeout),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   din;
        int            when;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic        rst_seen = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic [15:0]   hold_din  = '0;
    logic [15:0]   exp_cnt   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [15:0] d, input int w);
        wr_t e;
        e.addr = a;
        e.din  = d;
        e.when = w;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_seen = i_rst;
    end

    // Write-port monitor: every strobe must match the next queued write; idle bus must hold.
    always @(negedge clk) begin
        if (rst_seen) begin
            hold_addr = '0;
            hold_din  = '0;
        end
        if (o_ce || o_we) begin
            check("we_eq_ce", 32'(o_we), 32'(o_ce));
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(o_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(o_addr), 32'(mon_e.addr));
                check("wr_din", 32'(o_din), 32'(mon_e.din));
                check("wr_cycle", 32'(cyc), 32'(mon_e.when));
                hold_addr = mon_e.addr;
                hold_din  = mon_e.din;
            end
        end else begin
            check("hold_addr", 32'(o_addr), 32'(hold_addr));
            check("hold_din", 32'(o_din), 32'(hold_din));
        end
    end

    // Launches one frame at a negedge, queues the predicted writes, and checks
    // the valid latency, config handshake count and completion/timeout behaviour.
    task automatic run_frame(input logic [31:0] c, input logic [31:0] v, input int ncfg,
                             input logic [AW-1:0] ca, input logic [31:0] cd,
                             input logic ready, input int tick2_at, input int clr_at);
        int p0;
        int t;
        int credit;
        int sig_at;
        int hs;
        int lat;
        int vcnt;
        @(negedge clk);
        p0 = cyc;
        push_wr(AW'(0), c[15:0],  p0 + 1);
        push_wr(AW'(1), c[31:16], p0 + 2);
        push_wr(AW'(2), v[15:0],  p0 + 3);
        push_wr(AW'(3), v[31:16], p0 + 4);
        credit = CPF;
        t      = 5;
        sig_at = -1;
        for (int i = 0; i < ncfg; i++) begin
            push_wr(ca, cd[15:0], p0 + t + 1);
            push_wr(AW'(ca + AW'(1)), cd[31:16], p0 + t + 2);
            credit--;
            if (credit == 0) begin
                sig_at = t + 3;  // credit exhausted: no further acceptance slot
                break;
            end
            t += 3;
        end
        if (sig_at < 0) sig_at = t + 1;

        check("cfg_ready_idle", 32'(o_cfg_ready), 32'd0);
        check("busy_idle", 32'(o_busy), 32'd0);
        i_c_data    = c;
        i_v_data    = v;
        i_cfg_addr  = ca;
        i_cfg_data  = cd;
        i_cfg_valid = (ncfg > 0);
        i_w_ready   = ready;
        i_tick      = 1'b1;

        hs  = 0;
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            i_tick = (k == tick2_at);
            i_clr  = (k == clr_at);
            if (k == tick2_at) i_c_data = ~c;
            if (hs >= ncfg) i_cfg_valid = 1'b0;
            if (o_cfg_ready && i_cfg_valid) hs++;
            if (o_w_valid) lat = k;
        end
        i_tick      = 1'b0;
        i_clr       = 1'b0;
        i_cfg_valid = 1'b0;
        check("valid_latency", 32'(lat), 32'(sig_at));
        check("cfg_handshakes", 32'(hs), 32'(ncfg));

        if (ready) begin
            @(negedge clk);
            exp_cnt = exp_cnt + 16'd1;
            check("valid_fall", 32'(o_w_valid), 32'd0);
            check("busy_fall", 32'(o_busy), 32'd0);
            check("frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
        end else begin
            vcnt = 1;
            @(negedge clk);
            while (o_w_valid && vcnt < 100) begin
                vcnt++;
                @(negedge clk);
            end
            check("valid_high_cycles", 32'(vcnt), 32'(WT));
            check("timeout_flag", 32'(o_timeout), 32'd1);
            check("busy_after_timeout", 32'(o_busy), 32'd0);
            check("frame_cnt_timeout", 32'(o_frame_cnt), 32'(exp_cnt));
        end
        check("wr_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int p0;
        i_rst       = 1'b1;
        i_tick      = 1'b0;
        i_c_data    = '0;
        i_v_data    = '0;
        i_cfg_valid = 1'b0;
        i_cfg_addr  = '0;
        i_cfg_data  = '0;
        i_w_ready   = 1'b0;
        i_clr       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ce", 32'(o_ce), 32'd0);
        check("rst_we", 32'(o_we), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_din", 32'(o_din), 32'd0);
        check("rst_valid", 32'(o_w_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_cfg_ready", 32'(o_cfg_ready), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        i_rst = 1'b0;

        // Basic frame, no config traffic.
        run_frame(32'h1234_5678, 32'hCAFE_BABE, 0, '0, '0, 1'b1, -1, -1);

        // Full config credit with address wrap, then a single config write.
        run_frame(32'h0BAD_F00D, 32'h1357_9BDF, 2, 9'h1FF, 32'hAABB_CCDD, 1'b1, -1, -1);
        run_frame(32'hDEAD_BEEF, 32'h0102_0304, 1, 9'h0A0, 32'h1122_3344, 1'b1, -1, -1);

        // Overrun: dropped tick, then clear, then clear coinciding with a new overrun.
        check("overrun_pre", 32'(o_overrun), 32'd0);
        run_frame(32'hFEDC_BA98, 32'h7654_3210, 0, '0, '0, 1'b1, 3, -1);
        check("overrun_set", 32'(o_overrun), 32'd1);
        @(negedge clk);
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        check("overrun_clr", 32'(o_overrun), 32'd0);
        run_frame(32'h5555_AAAA, 32'h3333_CCCC, 0, '0, '0, 1'b1, 3, 3);
        check("overrun_set_wins", 32'(o_overrun), 32'd1);
        @(negedge clk);
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        check("overrun_clr2", 32'(o_overrun), 32'd0);

        // Handshake timeout.
        run_frame(32'h0F0F_F0F0, 32'h6789_ABCD, 0, '0, '0, 1'b0, -1, -1);
        @(negedge clk);
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        check("timeout_clr", 32'(o_timeout), 32'd0);

        // Reset while the first config low word is being written.
        @(negedge clk);
        p0 = cyc;
        push_wr(AW'(0), 16'h2222, p0 + 1);
        push_wr(AW'(1), 16'h1111, p0 + 2);
        push_wr(AW'(2), 16'h4444, p0 + 3);
        push_wr(AW'(3), 16'h3333, p0 + 4);
        push_wr(9'h055, 16'h7766, p0 + 6);
        i_c_data    = 32'h1111_2222;
        i_v_data    = 32'h3333_4444;
        i_cfg_addr  = 9'h055;
        i_cfg_data  = 32'h9988_7766;
        i_cfg_valid = 1'b1;
        i_w_ready   = 1'b1;
        i_tick      = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        repeat (4) @(negedge clk);
        check("cfg_ready_acc", 32'(o_cfg_ready), 32'd1);
        @(negedge clk);
        i_cfg_valid = 1'b0;
        check("ce_in_cfg_lo", 32'(o_ce), 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        exp_cnt = '0;
        check("mid_rst_ce", 32'(o_ce), 32'd0);
        check("mid_rst_addr", 32'(o_addr), 32'd0);
        check("mid_rst_din", 32'(o_din), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_valid", 32'(o_w_valid), 32'd0);
        check("mid_rst_cfg_ready", 32'(o_cfg_ready), 32'd0);
        check("mid_rst_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        run_frame(32'hA5A5_5A5A, 32'hC3C3_3C3C, 0, '0, '0, 1'b1, -1, -1);

        // Frame counter wrap from a preset of 0xFFFF.
        @(negedge clk);
        force dut.o_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.o_frame_cnt;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        check("frame_cnt_preset", 32'(o_frame_cnt), 32'(exp_cnt));
        run_frame(32'h0000_FFFF, 32'hFFFF_0000, 0, '0, '0, 1'b1, -1, -1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400us;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
